data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 9, byte address width (512-byte space, 128 words).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, wait states inserted between acceptance and response (legal 0..15).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_wr  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_funct3  input  3  access size/sign, RISC-V load/store encoding.
REQ-011 req_wdata  input  DATA_W  store data, right-aligned.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator accepts response.
REQ-014 rsp_rdata  output  DATA_W  load result, sign/zero-extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned or illegal.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL equal 1 only in IDLE.
REQ-017 IDLE: on req_valid && req_ready, latch req_wr/addr/funct3/wdata; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-018 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on acceptance, decrements each cycle; at 0, go to RESP.
REQ-019 rsp_valid SHALL rise exactly WAIT_CYCLES+1 edges after the accepting edge and hold, with stable rsp_rdata/rsp_err, until rsp_valid && rsp_ready.
REQ-020 RESP: on rsp_ready, go to IDLE; next acceptance no earlier than the following cycle (max throughput one request per WAIT_CYCLES+2 cycles).
REQ-021 Load data and store commit SHALL occur on the edge entering RESP; loads read memory state including all earlier committed stores.
REQ-022 Little-endian lanes: LB/LBU/SB use byte addr[1:0]; LH/LHU/SH use half addr[1]; LW/SW whole word at addr[ADDR_W-1:2].
REQ-023 funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores.
REQ-024 rsp_err=1, no memory write, rsp_rdata=0 when: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3[2]=1 or 011.
REQ-025 Stores SHALL write only the selected byte lanes; other lanes unchanged.
REQ-026 Inputs outside an accepting cycle SHALL be ignored; rsp_ready outside RESP SHALL be ignored.

Reset
REQ-027 While reset=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-028 Reset asserted in WAIT SHALL discard the pending request (no store commit); memory array contents SHALL NOT be reset.

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum, funct3 constants, DATA_W/ADDR_W defaults.
REQ-030 Storage SHALL be a sub-module dmem_array: 128 x DATA_W, synchronous write with 4-bit byte enable, combinational read.

Verification
REQ-031 WAIT_CYCLES=1: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_valid 2 edges after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-032 After REQ-031: LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
REQ-033 SB addr 0x011 data 0x00000055 then LW 0x010 -> 0xDEAD55EF.
REQ-034 SW 0x012 or LH 0x011 -> rsp_err=1, rdata 0; following LW 0x010 unchanged.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0 throughout; WAIT_CYCLES=0 -> response 1 edge after acceptance.
REQ-036 SW 0x020 0x12345678, reset asserted in WAIT -> outputs at reset values immediately; later LW 0x020 returns prior contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Flags encodings the responder does not implement and misaligned accesses.
  function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (wr) begin
      if (f3[2] || f3[1:0] == 2'b11) bad = 1'b1;
    end else begin
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
    end
    if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && a != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and asynchronous read.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  // Commit only the enabled byte lanes; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              enter_resp;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_f3;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_err;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;

  // Sign/zero-extend the addressed lane of a memory word.
  function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] w,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    return {{(DATA_W-8){b[7]}}, b};
      F3_H:    return {{(DATA_W-16){h[15]}}, h};
      F3_W:    return w;
      F3_BU:   return {{(DATA_W-8){1'b0}}, b};
      F3_HU:   return {{(DATA_W-16){1'b0}}, h};
      default: return '0;
    endcase
  endfunction

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes; enables pick the target.
  function automatic logic [DATA_W-1:0] store_data(input logic [2:0] f3,
                                                  input logic [DATA_W-1:0] w);
    case (f3[1:0])
      2'b00:   return {(DATA_W/8){w[7:0]}};
      2'b01:   return {(DATA_W/16){w[15:0]}};
      default: return w;
    endcase
  endfunction

  // When accepting with no wait states the access happens on the accepting
  // edge, so the live request is used; otherwise the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_wr    = req_wr;
      acc_addr  = req_addr;
      acc_f3    = req_funct3;
      acc_wdata = req_wdata;
    end else begin
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_f3    = f3_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_err = access_err(acc_wr, acc_f3, acc_addr[1:0]);

  // Next-state, wait counter and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_wr || acc_err) ? '0 : load_extract(mem_rdata, acc_f3, acc_addr[1:0]);
    end
  end

  assign mem_we    = enter_resp && acc_wr && !acc_err;
  assign mem_be    = store_be(acc_f3, acc_addr[1:0]);
  assign mem_wdata = store_data(acc_f3, acc_wdata);

  // Control and response registers; reset drops any pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture the accepted request for use in later cycles.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_wr;
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .AW     (WORD_AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (acc_addr[ADDR_W-1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
